imm_ext_unit: RTL and testbench
===============================

// Module: imm_ext_unit
// PURPOSE
//  Parametrised immediate extension unit for the datapath. Extends an IN_W-bit immediate to OUT_W bits
//  (sign/zero/high-place/word-offset) and adds a variable left-shift mode done iteratively, 1 bit/clk.
//  Valid/ready on both sides; sits between decode and the ALU-B operand mux; one request in flight.
// PARAMETERS
//  IN_W   16  immediate input width (2 <= IN_W < OUT_W)
//  OUT_W  32  extended output width
//  SH_W   5   shift-amount width; shamt >= OUT_W gives result 0
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  in_valid   in   1      request present on imm/eop/shamt
//  in_ready   out  1      unit can accept; transfer when in_valid & in_ready
//  imm        in   IN_W   immediate
//  eop        in   3      extension op (see BEHAVIOUR)
//  shamt      in   SH_W   left-shift amount, used by eop 100/101 only
//  out_valid  out  1      ext holds a result
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  ext        out  OUT_W  result, stable while out_valid & ~out_ready
//  err        out  1      qualified by out_valid: request used reserved eop
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Ops (S=sign-ext imm, Z=zero-ext imm to OUT_W):
//   000 S | 001 Z | 010 {imm, (OUT_W-IN_W) zeros} | 011 S<<2 (low 2 bits 0, top bits dropped)
//   100 S<<shamt iterative | 101 Z<<shamt iterative | 110/111 reserved: ext=0, err=1
//  FSM: IDLE, SHIFT, HOLD.
//   IDLE : in_ready=1. On accept: eop 100/101 with 0<shamt<OUT_W -> load base into acc, cnt=shamt, SHIFT;
//          all other cases -> final value into acc, HOLD.
//   SHIFT: acc<=acc<<1, cnt<=cnt-1 each clk; when cnt==1 the shift completes and state -> HOLD.
//   HOLD : out_valid=1, ext=acc. On out_ready: -> IDLE, or if in_valid same clk, accept next
//          request (in_ready = out_ready in HOLD) and go directly to SHIFT/HOLD per IDLE rules.
//  Latency (accept edge to out_valid): 1 clk for eop 0xx, reserved, shamt==0, shamt>=OUT_W;
//   1+shamt clks for eop 100/101 with 0<shamt<OUT_W. Back-to-back 1-clk ops: 1 result/clk.
//  in_ready=0 in SHIFT and in HOLD while out_ready=0. Inputs sampled only on accept edge.
//  Shift drops bits beyond OUT_W, fills 0 from LSB; sign taken from imm[IN_W-1] before shifting.
//  Reset (any time, incl. mid-SHIFT): state=IDLE, acc=0, cnt=0, ext=0, out_valid=0, err=0, busy=0,
//   in_ready=1 after release; in-flight request discarded.
//  out_valid/ext/err are registered; in_ready is combinational from state and out_ready.
// TESTING
//  1 eop=000 imm=16'h8001 -> 1 clk later ext=32'hFFFF8001; eop=001 same imm -> 32'h00008001.
//  2 eop=010 imm=16'h1234 -> 32'h12340000; eop=011 imm=16'hFFFF -> 32'hFFFFFFFC, err=0.
//  3 eop=100 imm=16'h8000 shamt=4 -> busy 4 clks, out_valid on clk 5, ext=32'hFFF80000;
//    shamt=0 -> 1 clk, 32'hFFFF8000.
//  4 Backpressure: out_ready=0 for 3 clks in HOLD -> ext stable, in_ready=0; raise out_ready with
//    in_valid=1 (eop=001 imm=16'h00FF) -> next result 32'h000000FF the following clk.
//  5 eop=110 -> ext=0, err=1; eop=101 imm=16'h0001 shamt=31 -> 32'h80000000 after 32 clks.
//  6 Assert reset mid-SHIFT (shamt=20, clk 5) -> all outputs 0 asynchronously, IDLE on release.

Source files
------------

// File: rtl/imm_ext_unit.sv
// rtl/imm_ext_unit.sv - immediate extension unit with iterative 1-bit/clk left-shift mode
// One request in flight; valid/ready handshakes on both sides.
module imm_ext_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SH_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm,
  input  logic [2:0]       eop,
  input  logic [SH_W-1:0]  shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] ext,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           r_state, w_state_nx;
  logic [OUT_W-1:0] r_acc, w_acc_nx;
  logic [SH_W-1:0]  r_cnt, w_cnt_nx;
  logic             r_err, w_err_nx;
  logic             r_out_valid;

  logic [OUT_W-1:0] w_sext, w_zext, w_base, w_final;
  logic             w_err_req, w_shamt_big, w_iter, w_accept;

  assign w_sext      = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign w_zext      = {{(OUT_W-IN_W){1'b0}}, imm};
  assign w_base      = eop[0] ? w_zext : w_sext;
  assign w_shamt_big = (32'(shamt) >= 32'(OUT_W));
  // Only non-trivial shift amounts take the iterative path; the rest finish in one clock.
  assign w_iter      = (eop[2:1] == 2'b10) && (shamt != '0) && !w_shamt_big;

  always_comb begin
    w_final   = '0;
    w_err_req = 1'b0;
    case (eop)
      3'b000:         w_final = w_sext;
      3'b001:         w_final = w_zext;
      3'b010:         w_final = {imm, {(OUT_W-IN_W){1'b0}}};
      3'b011:         w_final = {w_sext[OUT_W-3:0], 2'b00};
      3'b100, 3'b101: w_final = w_shamt_big ? '0 : w_base;
      default:        w_err_req = 1'b1;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nx = r_state;
    w_acc_nx   = r_acc;
    w_cnt_nx   = r_cnt;
    w_err_nx   = r_err;
    case (r_state)
      SHIFT: begin
        w_acc_nx = {r_acc[OUT_W-2:0], 1'b0};
        w_cnt_nx = r_cnt - {{(SH_W-1){1'b0}}, 1'b1};
        if (r_cnt == {{(SH_W-1){1'b0}}, 1'b1}) w_state_nx = HOLD;
      end
      HOLD:    if (out_ready) w_state_nx = IDLE;
      default: w_state_nx = r_state;
    endcase
    // Accept overrides HOLD's drain so back-to-back requests run at one result per clock.
    if (w_accept) begin
      if (w_iter) begin
        w_acc_nx   = w_base;
        w_cnt_nx   = shamt;
        w_err_nx   = 1'b0;
        w_state_nx = SHIFT;
      end else begin
        w_acc_nx   = w_final;
        w_cnt_nx   = '0;
        w_err_nx   = w_err_req;
        w_state_nx = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_acc       <= w_acc_nx;
      r_cnt       <= w_cnt_nx;
      r_err       <= w_err_nx;
      r_out_valid <= (w_state_nx == HOLD);
    end
  end

  assign out_valid = r_out_valid;
  assign ext       = r_acc;
  assign err       = r_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_imm_ext_unit.sv
// tb/tb_imm_ext_unit.sv - randomized and directed self-checking bench for imm_ext_unit
module tb_imm_ext_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] imm = '0;
  logic [2:0]  eop = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ext;
  logic        err;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  imm_ext_unit #(.IN_W(16), .OUT_W(32), .SH_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .eop(eop), .shamt(shamt), .out_valid(out_valid),
    .out_ready(out_ready), .ext(ext), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: arithmetic on 64-bit integers, truncated to 32 bits.
  function automatic void model(input logic [2:0] e, input logic [15:0] im, input logic [4:0] sh,
                                output logic [31:0] xe, output logic xr, output int xl);
    longint s, z, base;
    s  = longint'($signed(im));
    z  = longint'(im);
    xr = 1'b0;
    xl = 1;
    case (e)
      3'd0: xe = 32'(s);
      3'd1: xe = 32'(z);
      3'd2: xe = 32'(z * 65536);
      3'd3: xe = 32'(s * 4);
      3'd4, 3'd5: begin
        base = (e == 3'd4) ? s : z;
        xe   = 32'(base * (longint'(1) << sh));
        xl   = 1 + int'(sh);
      end
      default: begin xe = 32'd0; xr = 1'b1; end
    endcase
  endfunction

  task automatic run_req(input logic [2:0] e, input logic [15:0] im, input logic [4:0] sh, input int stall);
    logic [31:0] xe, held;
    logic        xr;
    int          xl, lat;
    model(e, im, sh, xe, xr, xl);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; eop = e; imm = im; shamt = sh;
    @(negedge clk);
    in_valid = 1'b0; eop = 3'($urandom); imm = 16'($urandom); shamt = 5'($urandom);
    lat = 1;
    if (xl > 1) begin
      chk("busy_shift", 64'(busy), 64'd1);
      chk("in_ready_shift", 64'(in_ready), 64'd0);
    end
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(xl));
    chk("ext", 64'(ext), 64'(xe));
    chk("err", 64'(err), 64'(xr));
    held = ext;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("ext_stable", 64'(ext), 64'(held));
      chk("in_ready_bp", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ext", 64'(ext), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    run_req(3'b000, 16'h8001, 5'd0, 0);
    run_req(3'b001, 16'h8001, 5'd0, 0);
    run_req(3'b010, 16'h1234, 5'd0, 0);
    run_req(3'b011, 16'hFFFF, 5'd0, 0);
    run_req(3'b100, 16'h8000, 5'd4, 0);
    run_req(3'b100, 16'h8000, 5'd0, 0);
    run_req(3'b110, 16'h5A5A, 5'd3, 0);
    run_req(3'b111, 16'hFFFF, 5'd7, 1);
    run_req(3'b101, 16'h0001, 5'd31, 0);
    run_req(3'b100, 16'hFFFF, 5'd31, 0);

    // Backpressure then same-clock drain + accept.
    @(negedge clk);
    in_valid = 1'b1; eop = 3'b000; imm = 16'h8001; shamt = 5'd0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_first", 64'(ext), 64'hFFFF8001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ext_stable", 64'(ext), 64'hFFFF8001);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1; in_valid = 1'b1; eop = 3'b001; imm = 16'h00FF;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_ext", 64'(ext), 64'h000000FF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    for (int n = 0; n < 60; n++)
      run_req(3'($urandom), 16'($urandom), 5'($urandom), int'($urandom_range(0, 2)));

    // Asynchronous reset mid-shift.
    @(negedge clk);
    in_valid = 1'b1; eop = 3'b100; imm = 16'h0001; shamt = 5'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_ext", 64'(ext), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    run_req(3'b101, 16'h0003, 5'd2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
